// File: rtl/uart_rx_fifo_if.sv
// Stream interface for uart_rx_fifo: the receiver-side input stream and the consumer-side output stream.
// The slave modport is the FIFO view. The master modport is the view of the surrounding logic.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] input_axis_tdata;
    logic                  input_axis_tvalid;
    logic                  input_axis_tready;
    logic [DATA_WIDTH-1:0] output_axis_tdata;
    logic                  output_axis_tvalid;
    logic                  output_axis_tready;

    modport slave (
        input  input_axis_tdata,
        input  input_axis_tvalid,
        output input_axis_tready,
        output output_axis_tdata,
        output output_axis_tvalid,
        input  output_axis_tready
    );

    modport master (
        output input_axis_tdata,
        output input_axis_tvalid,
        input  input_axis_tready,
        input  output_axis_tdata,
        input  output_axis_tvalid,
        output output_axis_tready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: it never backpressures, and it drops bytes with a sticky overflow when full.
// Defining UART_RX_FIFO_OUTREG_EN adds a one-entry registered output stage. That entry counts toward depth.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_rx_fifo_if.slave         axis,
    input  logic [ADDR_WIDTH:0]   threshold,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  level_irq,
    output logic                  overflow,
    input  logic                  overflow_clear
);
    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  tready_r;
    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [ADDR_WIDTH:0]   count_n;
    logic                  full_n, empty_n, level_n;
    logic                  push, pop, accept, drop, mem_pop;

    assign axis.input_axis_tready = tready_r;
    assign push   = axis.input_axis_tvalid && tready_r;
    assign pop    = axis.output_axis_tvalid && axis.output_axis_tready;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the byte
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    assign wr_ptr_n = wr_ptr + (ADDR_WIDTH+1)'(accept);
    assign rd_ptr_n = rd_ptr + (ADDR_WIDTH+1)'(mem_pop);
    assign level_n  = (threshold != '0) && (count_n >= threshold);

`ifdef UART_RX_FIFO_OUTREG_EN
    logic                  out_valid, out_valid_n, out_load;
    logic [DATA_WIDTH-1:0] out_data;

    // Refill the output register from storage whenever it is empty or being consumed
    assign out_load    = (wr_ptr != rd_ptr) && (!out_valid || pop);
    assign mem_pop     = out_load;
    assign out_valid_n = out_load || (out_valid && !pop);

    assign axis.output_axis_tvalid = out_valid;
    assign axis.output_axis_tdata  = out_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= out_valid_n;
            if (out_load) begin
                out_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    always_comb begin
        count_n = (wr_ptr_n - rd_ptr_n) + (ADDR_WIDTH+1)'(out_valid_n);
        full_n  = (count_n == DEPTH_C);
        empty_n = (count_n == '0);
    end
`else
    assign mem_pop = pop;

    assign axis.output_axis_tvalid = !empty;
    assign axis.output_axis_tdata  = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_comb begin
        count_n = wr_ptr_n - rd_ptr_n;
        full_n  = (wr_ptr_n[ADDR_WIDTH] != rd_ptr_n[ADDR_WIDTH]) &&
                  (wr_ptr_n[ADDR_WIDTH-1:0] == rd_ptr_n[ADDR_WIDTH-1:0]);
        empty_n = (wr_ptr_n == rd_ptr_n);
    end
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= axis.input_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            level_irq <= 1'b0;
            overflow  <= 1'b0;
            tready_r  <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            full      <= full_n;
            empty     <= empty_n;
            level_irq <= level_n;
            // A drop in the same cycle as a clear wins
            overflow  <= drop || (overflow && !overflow_clear);
            tready_r  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo. Bytes the FIFO should accept are queued, and the queue is compared against the output stream.
module tb_uart_rx_fifo;
    localparam int DW = 8;
    localparam int AW = 4;
`ifdef UART_RX_FIFO_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW:0]   threshold = '0;
    logic [AW:0]   count;
    logic          full, empty, level_irq, overflow;
    logic          overflow_clear = 1'b0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_b;
    int            n_cmp = 0;
    int            n_err = 0;

    uart_rx_fifo_if #(.DATA_WIDTH(DW)) axis ();

    uart_rx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .axis           (axis),
        .threshold      (threshold),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .level_irq      (level_irq),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit keep);
        axis.input_axis_tdata  = d;
        axis.input_axis_tvalid = 1'b1;
        if (keep) sb.push_back(d);
        tick();
        axis.input_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        axis.output_axis_tready = 1'b1;
        while ((!empty || sb.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        axis.output_axis_tready = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);
        check("drain_sb_left", 32'(sb.size()), 32'd0);
    endtask

    // Output stream monitor: a handshake seen here completes on the next rising edge
    always @(negedge clk) begin
        if (rst_n && axis.output_axis_tvalid && axis.output_axis_tready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                check("out_data", 32'(axis.output_axis_tdata), 32'(exp_b));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        axis.input_axis_tdata   = '0;
        axis.input_axis_tvalid  = 1'b0;
        axis.output_axis_tready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_tready", 32'(axis.input_axis_tready), 32'd0);
        check("rst_tvalid", 32'(axis.output_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(axis.output_axis_tdata), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_irq", 32'(level_irq), 32'd0);
        rst_n = 1'b1;
        tick();
        check("tready_after_rst", 32'(axis.input_axis_tready), 32'd1);

        // Back-to-back bytes with the consumer always ready
        axis.output_axis_tready = 1'b1;
        send(8'h41, 1'b1);
        check("first_valid_latency", 32'(axis.output_axis_tvalid), 32'(LAT == 1));
        send(8'h42, 1'b1);
        check("valid_after_2", 32'(axis.output_axis_tvalid), 32'd1);
        send(8'h43, 1'b1);
        drain(20);

        // Fill past full with the consumer stalled
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        check("fill_no_ovf", 32'(overflow), 32'd0);
        send(8'h10, 1'b0);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_count", 32'(count), 32'd16);
        check("drop_full", 32'(full), 32'd1);

        // Overflow clear, and clear coincident with another drop
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        overflow_clear = 1'b1;
        send(8'h77, 1'b0);
        overflow_clear = 1'b0;
        check("ovf_clear_vs_drop", 32'(overflow), 32'd1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_cleared_again", 32'(overflow), 32'd0);

        // Push and pop together while full
        axis.output_axis_tready = 1'b1;
        send(8'hAA, 1'b1);
        axis.output_axis_tready = 1'b0;
        check("full_pushpop_count", 32'(count), 32'd16);
        check("full_pushpop_full", 32'(full), 32'd1);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
        drain(40);

        // Watermark interrupt
        threshold = 5'd4;
        for (int i = 0; i < 4; i++) begin
            send(8'hC0 + 8'(i), 1'b1);
            check("irq_fill", 32'(level_irq), 32'(i == 3));
        end
        axis.output_axis_tready = 1'b1;
        tick();
        axis.output_axis_tready = 1'b0;
        check("irq_pop_count", 32'(count), 32'd3);
        check("irq_after_pop", 32'(level_irq), 32'd0);
        threshold = '0;
        for (int i = 0; i < 4; i++) begin
            send(8'hD0 + 8'(i), 1'b1);
            check("irq_thr_zero", 32'(level_irq), 32'd0);
        end
        drain(40);

        // Reset mid-operation discards stored bytes
        for (int i = 0; i < 5; i++) send(8'hE0 + 8'(i), 1'b1);
        check("pre_rst_count", 32'(count), 32'd5);
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_tvalid", 32'(axis.output_axis_tvalid), 32'd0);
        check("mid_rst_tready", 32'(axis.input_axis_tready), 32'd0);
        tick();
        check("post_rst_tready", 32'(axis.input_axis_tready), 32'd1);
        send(8'h55, 1'b1);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
